// File: rtl/ili9341_spi_reader.sv
// rtl/ili9341_spi_reader.sv - ILI9341 4-wire SPI read command issuer with 1-4 byte response capture
module ili9341_spi_reader #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [2:0]  rd_len,
    input  logic        dummy,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        tft_cs,
    output logic        tft_dc,
    output logic        tft_sck,
    output logic        tft_din,
    input  logic        tft_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DUMMY,
        S_READ,
        S_HOLD
    } state_t;

    localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [5:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    cmd_sh, cmd_sh_nxt;
    logic [2:0]    len, len_nxt;
    logic          dummy_r, dummy_nxt;
    logic [31:0]   shift, shift_nxt;
    logic          busy_nxt, done_nxt, cs_nxt, dc_nxt, sck_nxt, din_nxt;
    logic [31:0]   rd_data_nxt;
    logic          tick;
    logic [5:0]    rd_last;

    assign tick    = (cnt == HALF_LAST);
    // Index of the final read SCK cycle: 8*len - 1.
    assign rd_last = {len - 3'd1, 3'b111};

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = tick ? '0 : cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        cmd_sh_nxt  = cmd_sh;
        len_nxt     = len;
        dummy_nxt   = dummy_r;
        shift_nxt   = shift;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        rd_data_nxt = rd_data;
        cs_nxt      = tft_cs;
        dc_nxt      = tft_dc;
        sck_nxt     = tft_sck;
        din_nxt     = tft_din;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                // The done cycle is already IDLE, so a start there is rejected.
                if (start && !done) begin
                    state_nxt   = S_CMD;
                    cmd_sh_nxt  = {cmd[6:0], 1'b0};
                    din_nxt     = cmd[7];
                    cs_nxt      = 1'b0;
                    dc_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                    dummy_nxt   = dummy;
                    shift_nxt   = '0;
                    bit_cnt_nxt = '0;
                    if (rd_len == 3'd0)      len_nxt = 3'd1;
                    else if (rd_len > 3'd4)  len_nxt = 3'd4;
                    else                     len_nxt = rd_len;
                end
            end
            S_CMD, S_DUMMY, S_READ: begin
                if (tick) begin
                    sck_nxt = !tft_sck;
                    if (!tft_sck) begin
                        if (state == S_READ) shift_nxt = {shift[30:0], tft_dout};
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (state == S_CMD) begin
                            if (bit_cnt == 6'd7) begin
                                dc_nxt      = 1'b1;
                                din_nxt     = 1'b0;
                                bit_cnt_nxt = '0;
                                state_nxt   = dummy_r ? S_DUMMY : S_READ;
                            end else begin
                                din_nxt    = cmd_sh[7];
                                cmd_sh_nxt = {cmd_sh[6:0], 1'b0};
                            end
                        end else if (state == S_DUMMY) begin
                            bit_cnt_nxt = '0;
                            state_nxt   = S_READ;
                        end else if (bit_cnt == rd_last) begin
                            state_nxt = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    state_nxt   = S_IDLE;
                    cs_nxt      = 1'b1;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    rd_data_nxt = shift;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            cmd_sh  <= '0;
            len     <= 3'd1;
            dummy_r <= 1'b0;
            shift   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
            tft_cs  <= 1'b1;
            tft_dc  <= 1'b1;
            tft_sck <= 1'b0;
            tft_din <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            cmd_sh  <= cmd_sh_nxt;
            len     <= len_nxt;
            dummy_r <= dummy_nxt;
            shift   <= shift_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            rd_data <= rd_data_nxt;
            tft_cs  <= cs_nxt;
            tft_dc  <= dc_nxt;
            tft_sck <= sck_nxt;
            tft_din <= din_nxt;
        end
    end

endmodule

// File: tb/tb_ili9341_spi_reader.sv
// tb/tb_ili9341_spi_reader.sv - randomized bench for ili9341_spi_reader against a panel/transaction model
module tb_ili9341_spi_reader;

    localparam int CD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [2:0]  rd_len = 3'd1;
    logic        dummy = 1'b0;
    logic        busy, done, tft_cs, tft_dc, tft_sck, tft_din;
    logic [31:0] rd_data;
    logic        tft_dout = 1'b0;

    ili9341_spi_reader #(.CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .rd_len(rd_len),
        .dummy(dummy), .busy(busy), .done(done), .rd_data(rd_data),
        .tft_cs(tft_cs), .tft_dc(tft_dc), .tft_sck(tft_sck), .tft_din(tft_din),
        .tft_dout(tft_dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Panel model and bus monitor; transaction parameters set by the stimulus task.
    logic [31:0] m_resp = '0;
    int          m_pre = 8;
    int          m_bits = 8;
    int          rises = 0, falls = 0, stray = 0, dc_bad = 0, din_bad = 0;
    logic [7:0]  mosi = '0;
    logic        prev_sck = 1'b0, prev_cs = 1'b1;

    always @(negedge clk) begin
        if (prev_cs && !tft_cs) begin
            rises = 0; falls = 0; dc_bad = 0; din_bad = 0; mosi = '0;
        end
        if (tft_sck && !prev_sck) begin
            if (tft_cs) stray++;
            else begin
                if (rises < 8) begin
                    mosi = {mosi[6:0], tft_din};
                    if (tft_dc !== 1'b0) dc_bad++;
                end else begin
                    if (tft_dc !== 1'b1) dc_bad++;
                    if (tft_din !== 1'b0) din_bad++;
                end
                rises++;
            end
        end
        if (!tft_sck && prev_sck && !tft_cs) begin
            falls++;
            if (falls >= m_pre && (falls - m_pre) < m_bits)
                tft_dout = m_resp[m_bits - 1 - (falls - m_pre)];
            else
                tft_dout = 1'b0;
        end
        if (tft_cs) tft_dout = 1'b0;
        prev_sck = tft_sck;
        prev_cs  = tft_cs;
    end

    logic [31:0] last_rd = '0;

    task automatic run(input logic [7:0] c, input logic [2:0] l, input logic d,
                       input logic [31:0] resp, input bit poke, input int rst_k);
        int n, nsck, exp_k, k, busy_low;
        bit got;
        n = (l == 0) ? 1 : (l > 4) ? 4 : int'(l);
        nsck  = 8 + int'(d) + 8 * n;
        exp_k = 1 + 2 * CD * nsck + CD;
        @(negedge clk);
        cmd = c; rd_len = l; dummy = d;
        m_bits = 8 * n;
        m_pre  = 8 + int'(d);
        m_resp = (n == 4) ? resp : resp & ((32'h1 << m_bits) - 1);
        start = 1'b1;
        k = 0; got = 0; busy_low = 0;
        while (k < exp_k + 20) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (k == 1) begin
                check("accept_cs", tft_cs, 0);
                check("accept_dc", tft_dc, 0);
                check("accept_din", tft_din, c[7]);
                check("accept_busy", busy, 1);
                check("accept_sck", tft_sck, 0);
                check("rd_data_kept", rd_data, last_rd);
            end
            if (rst_k > 0 && k == rst_k) reset = 1'b1;
            if (rst_k > 0 && k == rst_k + 1) begin
                reset = 1'b0;
                check("abort_cs", tft_cs, 1);
                check("abort_sck", tft_sck, 0);
                check("abort_busy", busy, 0);
                check("abort_rd_data", rd_data, 0);
                check("abort_done", done, 0);
                last_rd = '0;
            end
            if (poke && k == exp_k / 2) start = 1'b1;
            if (done) begin
                got = 1;
                break;
            end
            if (rst_k == 0 && busy !== 1'b1) busy_low++;
        end
        if (rst_k > 0) begin
            check("abort_no_done", 32'(got), 0);
        end else begin
            check("done_seen", 32'(got), 1);
            check("latency", k, exp_k);
            check("rd_data", rd_data, m_resp);
            check("busy_at_done", busy, 0);
            check("busy_gaps", busy_low, 0);
            check("sck_rises", rises, nsck);
            check("mosi_cmd", mosi, c);
            check("dc_phase", dc_bad, 0);
            check("din_read_low", din_bad, 0);
            check("stray_rises", stray, 0);
            last_rd = m_resp;
            if (poke) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("done_single", done, 0);
                check("late_start_ignored", busy, 0);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cs", tft_cs, 1);
        check("rst_sck", tft_sck, 0);
        check("rst_dc", tft_dc, 1);
        check("rst_din", tft_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;

        run(8'h04, 3'd3, 1'b1, 32'h00009341, 0, 0);
        run(8'h0A, 3'd1, 1'b0, 32'h0000009C, 0, 0);
        run(8'hA5, 3'd2, 1'b0, $urandom(), 0, 0);
        run(8'h3C, 3'd0, 1'b0, $urandom(), 0, 0);
        run(8'hD3, 3'd7, 1'b1, 32'hDEADBEEF, 0, 0);
        run(8'h09, 3'd4, 1'b0, $urandom(), 1, 0);
        run(8'h0B, 3'd2, 1'b0, $urandom(), 0, 0);
        run(8'h04, 3'd3, 1'b1, $urandom(), 0, 1 + 2 * CD * (9 + 5) + CD + 1);
        run(8'h0C, 3'd2, 1'b1, $urandom(), 0, 0);
        for (int i = 0; i < 8; i++)
            run(8'($urandom()), 3'($urandom_range(0, 7)), 1'($urandom()), $urandom(),
                bit'($urandom_range(0, 1)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
